// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - state encoding, match defaults and playfield constants for the pong match controller
package pong_pkg;

  localparam int WIN_SCORE_DEF   = 5;
  localparam int SERVE_DELAY_DEF = 8;
  localparam int POINT_HOLD_DEF  = 16;

  localparam int LEFT_MOST  = 0;
  localparam int RIGHT_MOST = 639;
  localparam int UP_MOST    = 0;
  localparam int DOWN_MOST  = 479;
  localparam int BAR1_Y     = 8;
  localparam int BAR2_Y     = 470;
  localparam int BAR_LEN    = 64;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_RALLY      = 3'd2,
    ST_POINT      = 3'd3,
    ST_OVER       = 3'd4
`ifdef PONG_PAUSE_EN
    , ST_PAUSED   = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - two-flop synchronizer plus registered rising-edge pulse for a raw button
module btn_edge (
  input  logic CLK,
  input  logic RSTn,
  input  logic btn,
  output logic rise
);

  logic sync1, sync2, sync3;

  // rise lands 3 CLK after btn goes high: two sync stages plus the registered edge
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      sync3 <= sync2;
      rise  <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - pong match sequencing and scoring; PONG_PAUSE_EN adds a start-button pause during rallies
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int SERVE_DELAY = SERVE_DELAY_DEF,
  parameter int POINT_HOLD  = POINT_HOLD_DEF
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        tick,
  input  logic        start_btn,
  input  logic        miss_p1,
  input  logic        miss_p2,
  output logic        ball_run,
  output logic        ball_load,
  output logic        serve_side,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic [13:0] score_disp,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  state
);

  localparam int         CNT_W = 16;
  localparam logic [3:0] WIN4  = 4'(WIN_SCORE);

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         score_p1_q, score_p2_q;
  logic               serve_q, winner_q;
  logic [13:0]        disp_q;
  logic               start_ev;
  logic               award_p1, award_p2, clr_scores, latch_win, counting;

  btn_edge u_start_edge (
    .CLK  (CLK),
    .RSTn (RSTn),
    .btn  (start_btn),
    .rise (start_ev)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_q;
    ball_load  = 1'b0;
    award_p1   = 1'b0;
    award_p2   = 1'b0;
    clr_scores = 1'b0;
    latch_win  = 1'b0;
    counting   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ev) state_nxt = ST_SERVE_WAIT;
      end
      ST_SERVE_WAIT: begin
        counting = 1'b1;
        if (tick && cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
          ball_load = 1'b1;
          state_nxt = ST_RALLY;
        end
      end
      ST_RALLY: begin
        // a simultaneous double miss is a replay: no point, serve unchanged
        if (miss_p1 || miss_p2) begin
          award_p2  = miss_p1 & ~miss_p2;
          award_p1  = miss_p2 & ~miss_p1;
          state_nxt = ST_POINT;
        end
`ifdef PONG_PAUSE_EN
        else if (start_ev) begin
          state_nxt = ST_PAUSED;
        end
`endif
      end
      ST_POINT: begin
        counting = 1'b1;
        if (tick && cnt_q == CNT_W'(POINT_HOLD - 1)) begin
          if (score_p1_q == WIN4 || score_p2_q == WIN4) begin
            latch_win = 1'b1;
            state_nxt = ST_OVER;
          end else begin
            state_nxt = ST_SERVE_WAIT;
          end
        end
      end
      ST_OVER: begin
        if (start_ev) begin
          clr_scores = 1'b1;
          state_nxt  = ST_SERVE_WAIT;
        end
      end
`ifdef PONG_PAUSE_EN
      ST_PAUSED: begin
        if (start_ev) state_nxt = ST_RALLY;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // any state change restarts the tick count so every timed state begins at zero
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                  cnt_q <= '0;
    else if (state_nxt != state_q) cnt_q <= '0;
    else if (tick && counting)  cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      score_p1_q <= '0;
      score_p2_q <= '0;
      serve_q    <= 1'b0;
      winner_q   <= 1'b0;
      disp_q     <= '0;
    end else begin
      if (clr_scores) begin
        score_p1_q <= '0;
        score_p2_q <= '0;
      end else begin
        if (award_p1 && score_p1_q != WIN4) score_p1_q <= score_p1_q + 4'd1;
        if (award_p2 && score_p2_q != WIN4) score_p2_q <= score_p2_q + 4'd1;
      end
      if (award_p1)      serve_q <= 1'b1;
      else if (award_p2) serve_q <= 1'b0;
      if (latch_win) winner_q <= (score_p2_q == WIN4);
      disp_q <= 14'(score_p1_q) * 14'd100 + 14'(score_p2_q);
    end
  end

  assign ball_run   = (state_q == ST_RALLY);
  assign game_over  = (state_q == ST_OVER);
  assign serve_side = serve_q;
  assign score_p1   = score_p1_q;
  assign score_p2   = score_p2_q;
  assign score_disp = disp_q;
  assign winner     = winner_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - randomized self-checking bench for pong_match_ctrl against a match-level model
module tb_pong_match_ctrl;
  import pong_pkg::*;

  localparam int WIN = 5;
  localparam int SD  = 8;
  localparam int PH  = 16;

  localparam int P_IDLE = 0, P_SW = 1, P_RALLY = 2, P_POINT = 3, P_OVER = 4, P_PAUSED = 5;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        tick = 1'b0, start_btn = 1'b0, miss_p1 = 1'b0, miss_p2 = 1'b0;
  logic        ball_run, ball_load, serve_side, game_over, winner;
  logic [3:0]  score_p1, score_p2;
  logic [13:0] score_disp;
  logic [2:0]  state;

  int tests_run = 0;
  int tests_failed = 0;

  pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_DELAY(SD), .POINT_HOLD(PH)) dut (
    .CLK(CLK), .RSTn(RSTn), .tick(tick), .start_btn(start_btn),
    .miss_p1(miss_p1), .miss_p2(miss_p2), .ball_run(ball_run), .ball_load(ball_load),
    .serve_side(serve_side), .score_p1(score_p1), .score_p2(score_p2),
    .score_disp(score_disp), .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 CLK = ~CLK;

  // match-level model
  int   m_ph, m_s1, m_s2, m_serve, m_win, m_disp, m_ticks;
  logic bh [4];

  logic [2:0]  obs_state;
  logic [3:0]  obs_s1, obs_s2;
  logic [13:0] obs_disp;
  logic        obs_serve, obs_win, obs_run, obs_load, obs_over, exp_load;
  logic [29:0] obs_vec, exp_vec;

  function automatic logic [2:0] code(input int ph);
    case (ph)
      P_IDLE:  return ST_IDLE;
      P_SW:    return ST_SERVE_WAIT;
      P_RALLY: return ST_RALLY;
      P_POINT: return ST_POINT;
      P_OVER:  return ST_OVER;
`ifdef PONG_PAUSE_EN
      P_PAUSED: return ST_PAUSED;
`endif
      default: return 3'd7;
    endcase
  endfunction

  task automatic model_reset;
    m_ph = P_IDLE; m_s1 = 0; m_s2 = 0; m_serve = 0; m_win = 0; m_disp = 0; m_ticks = 0;
    for (int i = 0; i < 4; i++) bh[i] = 1'b0;
  endtask

  // start event this cycle = button seen high at edge n-3 and low at edge n-4
  task automatic model_update(input logic t, input logic m1, input logic m2, input logic b);
    logic ev;
    ev = bh[2] & ~bh[3];
    m_disp = m_s1 * 100 + m_s2;
    case (m_ph)
      P_IDLE: if (ev) begin m_ph = P_SW; m_ticks = 0; end
      P_SW: if (t) begin
        m_ticks++;
        if (m_ticks == SD) m_ph = P_RALLY;
      end
      P_RALLY: begin
        if (m1 || m2) begin
          if (m1 && !m2) begin m_s2++; m_serve = 0; end
          if (m2 && !m1) begin m_s1++; m_serve = 1; end
          m_ph = P_POINT; m_ticks = 0;
        end
`ifdef PONG_PAUSE_EN
        else if (ev) m_ph = P_PAUSED;
`endif
      end
      P_POINT: if (t) begin
        m_ticks++;
        if (m_ticks == PH) begin
          if (m_s1 == WIN || m_s2 == WIN) begin m_ph = P_OVER; m_win = (m_s2 == WIN); end
          else begin m_ph = P_SW; m_ticks = 0; end
        end
      end
      P_OVER: if (ev) begin m_s1 = 0; m_s2 = 0; m_ph = P_SW; m_ticks = 0; end
      P_PAUSED: if (ev) m_ph = P_RALLY;
      default: m_ph = P_IDLE;
    endcase
    bh[3] = bh[2]; bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = b;
  endtask

  task automatic step(input logic t, input logic m1, input logic m2, input logic b);
    @(negedge CLK);
    tick = t; miss_p1 = m1; miss_p2 = m2; start_btn = b;
    #1;
    obs_state = state; obs_s1 = score_p1; obs_s2 = score_p2; obs_disp = score_disp;
    obs_serve = serve_side; obs_win = winner; obs_run = ball_run; obs_load = ball_load;
    obs_over = game_over;
    exp_load = (m_ph == P_SW) && t && (m_ticks + 1 == SD);
    obs_vec = {obs_state, obs_s1, obs_s2, obs_disp, obs_serve, obs_win, obs_run, obs_load, obs_over};
    exp_vec = {code(m_ph), 4'(m_s1), 4'(m_s2), 14'(m_disp), m_serve[0], m_win[0],
               (m_ph == P_RALLY), exp_load, (m_ph == P_OVER)};
    @(posedge CLK);
    model_update(t, m1, m2, b);
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RSTn = 1'b0; tick = 0; start_btn = 0; miss_p1 = 0; miss_p2 = 0;
    repeat (2) @(negedge CLK);
    model_reset();
    RSTn = 1'b1;
  endtask

  task automatic go_phase(input int target);
    int guard = 0;
    while (m_ph != target && guard < 400) begin
      step(1'($urandom_range(0, 1)), 0, 0, 0);
      guard++;
    end
    tests_run++;
    if (m_ph != target) begin
      tests_failed++;
      $display("FAIL go_phase timeout got=%0d want=%0d", m_ph, target);
    end
  endtask

  task automatic start_rally;
    do_reset();
    step(0, 0, 0, 1);
    go_phase(P_RALLY);
  endtask

  task automatic test_reset;
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    tests_run++;
    if ({state, score_p1, score_p2, score_disp} !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_state_scores got=%0h want=0", {state, score_p1, score_p2, score_disp});
    end
    tests_run++;
    if ({serve_side, winner, ball_run, ball_load, game_over} !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b want=00000", {serve_side, winner, ball_run, ball_load, game_over});
    end
    do_reset();
  endtask

  task automatic test_serve;
    int loads = 0, ticks = 0, tick_at_load = 0, guard = 0;
    logic t;
    do_reset();
    step(0, 0, 0, 1);
    while (m_ph != P_SW && guard < 20) begin step(0, 0, 0, 0); guard++; end
    step(0, 0, 0, 0);
    tests_run++;
    if (obs_state !== ST_SERVE_WAIT) begin
      tests_failed++;
      $display("FAIL serve_enter got=%0d want=%0d", obs_state, ST_SERVE_WAIT);
    end
    guard = 0;
    while (m_ph == P_SW && guard < 200) begin
      t = 1'($urandom_range(0, 1));
      step(t, 0, 0, 0);
      if (t) ticks++;
      if (obs_load === 1'b1) begin loads++; tick_at_load = ticks; end
      tests_run++;
      if (obs_load !== exp_load) begin
        tests_failed++;
        $display("FAIL serve_load_cycle got=%b want=%b", obs_load, exp_load);
      end
      guard++;
    end
    tests_run++;
    if (loads != 1 || tick_at_load != SD) begin
      tests_failed++;
      $display("FAIL serve_load_once got=%0d@%0d want=1@%0d", loads, tick_at_load, SD);
    end
    step(0, 0, 0, 0);
    tests_run++;
    if (obs_run !== 1'b1) begin
      tests_failed++;
      $display("FAIL serve_run_after got=%b want=1", obs_run);
    end
  endtask

  task automatic test_point_p1;
    start_rally();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    tests_run++;
    if ({obs_s1, obs_s2, obs_serve, obs_run, obs_state} !== {4'd1, 4'd0, 1'b1, 1'b0, ST_POINT}) begin
      tests_failed++;
      $display("FAIL point_p1_score got=%0h want=%0h", {obs_s1, obs_s2, obs_serve, obs_run, obs_state},
               {4'd1, 4'd0, 1'b1, 1'b0, ST_POINT});
    end
    step(0, 0, 0, 0);
    tests_run++;
    if (obs_disp !== 14'd100) begin
      tests_failed++;
      $display("FAIL point_p1_disp got=%0d want=100", obs_disp);
    end
    repeat (PH - 1) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    tests_run++;
    if (obs_state !== ST_POINT) begin
      tests_failed++;
      $display("FAIL point_hold_early got=%0d want=%0d", obs_state, ST_POINT);
    end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    tests_run++;
    if (obs_state !== ST_SERVE_WAIT) begin
      tests_failed++;
      $display("FAIL point_hold_end got=%0d want=%0d", obs_state, ST_SERVE_WAIT);
    end
  endtask

  task automatic test_replay;
    start_rally();
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    tests_run++;
    if ({obs_s1, obs_s2, obs_serve, obs_state} !== {4'd0, 4'd0, 1'b0, ST_POINT}) begin
      tests_failed++;
      $display("FAIL replay_point got=%0h want=%0h", {obs_s1, obs_s2, obs_serve, obs_state},
               {4'd0, 4'd0, 1'b0, ST_POINT});
    end
    go_phase(P_SW);
    step(0, 0, 0, 0);
    tests_run++;
    if ({obs_s1, obs_s2, obs_state} !== {4'd0, 4'd0, ST_SERVE_WAIT}) begin
      tests_failed++;
      $display("FAIL replay_serve got=%0h want=%0h", {obs_s1, obs_s2, obs_state}, {8'd0, ST_SERVE_WAIT});
    end
  endtask

  task automatic test_ignored_events;
    do_reset();
    step(0, 0, 0, 1);
    go_phase(P_SW);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    tests_run++;
    if ({obs_s1, obs_s2, obs_state} !== {4'd0, 4'd0, ST_SERVE_WAIT}) begin
      tests_failed++;
      $display("FAIL miss_in_serve got=%0h want=%0h", {obs_s1, obs_s2, obs_state}, {8'd0, ST_SERVE_WAIT});
    end
    go_phase(P_RALLY);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0);
    tests_run++;
    if ({obs_s1, obs_s2, obs_state} !== {4'd1, 4'd0, ST_POINT}) begin
      tests_failed++;
      $display("FAIL start_in_point got=%0h want=%0h", {obs_s1, obs_s2, obs_state}, {8'h10, ST_POINT});
    end
`ifndef PONG_PAUSE_EN
    go_phase(P_RALLY);
    step(0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0);
    tests_run++;
    if ({obs_run, obs_state} !== {1'b1, ST_RALLY}) begin
      tests_failed++;
      $display("FAIL start_in_rally got=%0h want=%0h", {obs_run, obs_state}, {1'b1, ST_RALLY});
    end
`endif
  endtask

  task automatic test_match;
    start_rally();
    for (int i = 0; i < WIN; i++) begin
      go_phase(P_RALLY);
      step(0, 1, 0, 0);
    end
    go_phase(P_OVER);
    step(0, 0, 0, 0);
    tests_run++;
    if ({obs_over, obs_win, obs_s2, obs_state} !== {1'b1, 1'b1, 4'd5, ST_OVER}) begin
      tests_failed++;
      $display("FAIL match_over got=%0h want=%0h", {obs_over, obs_win, obs_s2, obs_state},
               {1'b1, 1'b1, 4'd5, ST_OVER});
    end
    tests_run++;
    if (obs_disp !== 14'd5) begin
      tests_failed++;
      $display("FAIL match_disp got=%0d want=5", obs_disp);
    end
    step(0, 0, 0, 1);
    go_phase(P_SW);
    step(0, 0, 0, 0);
    tests_run++;
    if ({obs_s1, obs_s2, obs_serve, obs_state} !== {4'd0, 4'd0, 1'b0, ST_SERVE_WAIT}) begin
      tests_failed++;
      $display("FAIL match_restart got=%0h want=%0h", {obs_s1, obs_s2, obs_serve, obs_state},
               {9'd0, ST_SERVE_WAIT});
    end
  endtask

  task automatic test_rally_reset;
    start_rally();
    step(1, 0, 0, 0);
    @(negedge CLK);
    #2 RSTn = 1'b0;
    #1;
    tests_run++;
    if ({state, score_p1, score_p2, score_disp, serve_side, winner, ball_run, ball_load, game_over} !== 30'd0) begin
      tests_failed++;
      $display("FAIL rally_reset got=%0h want=0",
               {state, score_p1, score_p2, score_disp, serve_side, winner, ball_run, ball_load, game_over});
    end
    do_reset();
  endtask

`ifdef PONG_PAUSE_EN
  task automatic test_pause;
    int loads = 0;
    start_rally();
    step(0, 0, 0, 1);
    go_phase(P_PAUSED);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    tests_run++;
    if ({obs_run, obs_s1, obs_s2, obs_state} !== {1'b0, 8'd0, ST_PAUSED}) begin
      tests_failed++;
      $display("FAIL pause_hold got=%0h want=%0h", {obs_run, obs_s1, obs_s2, obs_state}, {9'd0, ST_PAUSED});
    end
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      if (obs_load === 1'b1) loads++;
    end
    tests_run++;
    if ({loads[3:0], obs_run, obs_state} !== {4'd0, 1'b1, ST_RALLY}) begin
      tests_failed++;
      $display("FAIL pause_resume got=%0h want=%0h", {loads[3:0], obs_run, obs_state}, {5'd1, ST_RALLY});
    end
  endtask
`endif

  task automatic test_random_soak;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 11) == 0));
      tests_run++;
      if (obs_vec !== exp_vec) begin
        tests_failed++;
        $display("FAIL soak_cycle_%0d got=%0h want=%0h", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_serve();
    test_point_p1();
    test_replay();
    test_ignored_events();
    test_match();
    test_rally_reset();
`ifdef PONG_PAUSE_EN
    test_pause();
`endif
    test_random_soak();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 5, is the points that end a match (range 1..9).
REQ-002 Parameter SERVE_DELAY, default 8, is the number of tick pulses waited before each serve.
REQ-003 Parameter POINT_HOLD, default 16, is the number of tick pulses the frozen display is held after a point.
REQ-004 CLK  in  1  system clock.
REQ-005 RSTn  in  1  reset, asynchronous, active-low.
REQ-006 tick  in  1  one-CLK pulse at ball-step rate, used as the timebase.
REQ-007 start_btn  in  1  raw start/pause button, asynchronous to CLK.
REQ-008 miss_p1  in  1  one-CLK pulse: ball passed player-1 (top) bar.
REQ-009 miss_p2  in  1  one-CLK pulse: ball passed player-2 (bottom) bar.
REQ-010 ball_run  out  1  high while the ball engine may advance.
REQ-011 ball_load  out  1  one-CLK pulse: ball engine reloads its serve position.
REQ-012 serve_side  out  1  0 = player 1 serves, 1 = player 2 serves.
REQ-013 score_p1, score_p2  out  4 each  binary points.
REQ-014 score_disp  out  14  score_p1*100 + score_p2, for the 4-digit 7-segment driver.
REQ-015 game_over  out  1  high in state OVER.
REQ-016 winner  out  1  0 = player 1, 1 = player 2; valid while game_over is high.
REQ-017 state  out  3  current FSM state code.

Function
REQ-018 start_btn SHALL pass through a 2-flop synchronizer and rising-edge detector; start_ev is a one-CLK pulse asserted 3 CLK after the input rises.
REQ-019 FSM states: IDLE, SERVE_WAIT, RALLY, POINT, OVER (plus PAUSED, see Configuration).
REQ-020 IDLE -> SERVE_WAIT on start_ev; the tick counter clears on entry to every timed state.
REQ-021 SERVE_WAIT SHALL count tick pulses; on the SERVE_DELAY-th tick it SHALL pulse ball_load for that same cycle and enter RALLY on the next CLK.
REQ-022 ball_run SHALL be 1 only in RALLY; 0 in all other states.
REQ-023 In RALLY, miss_p1 alone SHALL increment score_p2, set serve_side=0, and enter POINT.
REQ-024 In RALLY, miss_p2 alone SHALL increment score_p1, set serve_side=1, and enter POINT.
REQ-025 miss_p1 and miss_p2 in the same cycle SHALL award no point, leave serve_side unchanged, and enter POINT (replay).
REQ-026 miss pulses outside RALLY SHALL be ignored.
REQ-027 In POINT, after POINT_HOLD ticks: if either score equals WIN_SCORE, enter OVER; otherwise enter SERVE_WAIT.
REQ-028 winner SHALL latch on entry to OVER; scores SHALL never exceed WIN_SCORE.
REQ-029 OVER -> SERVE_WAIT on start_ev, clearing both scores in that cycle and keeping serve_side.
REQ-030 start_ev in SERVE_WAIT or POINT SHALL be ignored; in RALLY it is ignored unless PONG_PAUSE_EN is defined.
REQ-031 score_disp SHALL be registered, updating one CLK after a score change.

Reset
REQ-032 On RSTn low: state=IDLE, scores=0, score_disp=0, serve_side=0, winner=0, ball_run=0, ball_load=0, game_over=0, counters and synchronizer flops=0.
REQ-033 Reset asserted mid-rally SHALL abort immediately with no ball_load pulse emitted.

Configuration
REQ-034 With PONG_PAUSE_EN defined: start_ev in RALLY enters PAUSED (ball_run=0, misses ignored); start_ev in PAUSED returns to RALLY without a ball_load pulse.
REQ-035 Without PONG_PAUSE_EN: no PAUSED state exists, and start_ev in RALLY has no effect.

Structure
REQ-036 Shared package pong_pkg SHALL hold the state encoding, the WIN_SCORE/SERVE_DELAY/POINT_HOLD defaults, and the playfield constants (LEFT_MOST, RIGHT_MOST, UP_MOST, DOWN_MOST, BAR1_Y, BAR2_Y, bar length).
REQ-037 One sub-module, btn_edge (synchronizer plus rising-edge detector), SHALL be instantiated for start_btn.

Verification
REQ-038 Reset, start_btn rising, 8 ticks -> ball_load pulses once on the 8th tick; ball_run=1 the next CLK.
REQ-039 In RALLY, miss_p2 pulse -> score_p1=1, score_disp=100, serve_side=1, ball_run=0; SERVE_WAIT after 16 ticks.
REQ-040 miss_p1 and miss_p2 in the same cycle -> scores unchanged, POINT then SERVE_WAIT.
REQ-041 Five miss_p1 events -> score_p2=5, state OVER after hold, game_over=1, winner=1; start_ev -> scores 0, SERVE_WAIT.
REQ-042 miss_p1 in SERVE_WAIT, and start_ev in POINT -> no change.
REQ-043 PONG_PAUSE_EN defined: start_ev in RALLY -> PAUSED with ball_run=0; miss ignored; second start_ev -> RALLY with no ball_load. Reset asserted in RALLY -> all outputs at reset values.
